wall_probe: RTL
===============

Name: wall_probe

Overview:
- Reads the composed VGA pixel stream after the background/draw stages, the reverse direction to the drawing path.
- For a sprite rectangle, reports per frame whether wall-coloured pixels touch each of its four edges and whether a dot pixel lies inside it.
- Feeds game/movement logic so the player cannot move into walls and dots can be eaten.
- Pure sink on the VGA interface; the stream is not modified.

Parameters:
- SPRITE_SIZE, 16, sprite side length in pixels.
- WALL_RGB, BLUE (vga_pkg), colour treated as wall.
- DOT_RGB, 12'h0ff, colour treated as an edible dot.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- vga_in  vga_if.in  -  composed stream: hcount, vcount, hblnk, vblnk, hsync, vsync, rgb; rgb aligned with hcount/vcount in the same cycle
- pos_x  in  11  sprite top-left x
- pos_y  in  11  sprite top-left y
- blocked  out  4  bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT; 1 = wall adjacent
- dot_hit  out  1  dot pixel found inside the sprite body last frame
- frame_done  out  1  one-cycle pulse when blocked/dot_hit update
- valid  out  1  set after the first commit; stays 1 until reset

Behaviour:
- Reset (rst=0, async): all outputs 0; accumulators 0; position snapshot 0; state WAIT.
- Frame start: vblnk 1->0 edge, detected with a registered copy of vblnk. Frame end: vblnk 0->1 edge.
- Position snapshot:
  - sx,sy <= pos_x,pos_y on the cycle the frame-start edge is detected.
  - Changes to pos_x/pos_y mid-frame have no effect until the next frame start.
- Probe strips, computed in 12-bit unsigned arithmetic, no wrap:
  - UP: row sy-1, cols sx..sx+SIZE-1
  - DOWN: row sy+SIZE, cols sx..sx+SIZE-1
  - LEFT: col sx-1, rows sy..sy+SIZE-1
  - RIGHT: col sx+SIZE, rows sy..sy+SIZE-1
  - Diagonal corner pixels belong to no strip.
- Body: cols sx..sx+SIZE-1, rows sy..sy+SIZE-1.
- Screen-edge rule (evaluated from the snapshot, forced into the commit):
  - sy==0 -> UP=1; sx==0 -> LEFT=1
  - sy+SIZE>=VER_PIXELS -> DOWN=1; sx+SIZE>=HOR_PIXELS -> RIGHT=1
- FSM:
  - WAIT: ignore the stream. On frame start -> SCAN (take snapshot, clear accumulators).
  - SCAN: each cycle with hblnk=0 and vblnk=0:
    - rgb==WALL_RGB and pixel in strip d -> acc[d] <= 1
    - rgb==DOT_RGB and pixel in body -> acc_dot <= 1
    - Accumulators are sticky OR.
    - On frame end -> COMMIT.
  - COMMIT, one cycle:
    - blocked <= acc | edge_flags; dot_hit <= acc_dot; frame_done <= 1; valid <= 1
    - Clear accumulators, then -> WAIT.
- Latency: outputs update 2 cycles after vblnk rises at the input (1 cycle edge detect, 1 cycle commit).
- frame_done is high only in the cycle after COMMIT; 0 otherwise.
- Outputs hold between commits.
- Reset mid-frame: the partial frame is discarded. The first commit after reset needs one full frame starting from a frame-start edge.
- Pixels during blanking are never sampled.
- WALL_RGB==DOT_RGB is not supported.

Decomposition:
- vga_pkg additions:
  - typedef enum dir_e {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} for blocked indices
  - WALL_RGB/DOT_RGB defaults as named constants alongside BLUE
- Existing HOR_PIXELS/VER_PIXELS are reused.
- One sub-module: wall_probe_strip, a combinational range test (hcount, vcount, x0, x1, y0, y1 -> hit), instantiated five times (four strips plus body).
- FSM and accumulators live in the top.

Test Plan (SIZE=16; bench-generated 1024x768 stream, black except the listed pixels):
1. rst pulsed low mid-SCAN -> outputs 0 immediately, valid=0; first frame_done only at the end of the next complete frame; no frame_done for the interrupted frame.
2. Sprite (500,200), WALL pixel at (505,199) -> after commit blocked=4'b0001, frame_done high exactly 1 cycle, valid=1.
3. Sprite (500,200), WALL at (516,210) -> blocked=4'b1000; WALL only at (516,216) (corner) -> blocked=4'b0000.
4. Sprite (0,0), empty frame -> blocked=4'b0101; sprite (1008,752) -> blocked=4'b1010.
5. Sprite (505,380), DOT at (512,384) -> dot_hit=1; next frame without the dot -> dot_hit=0; DOT at (504,384) -> dot_hit=0.
6. Sprite (500,200), WALL at (505,199); pos changed to (100,100) at vcount=400 -> that frame reports blocked=4'b0001; next frame with the same stream -> blocked=4'b0000.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and types.
// Screen geometry, colours and probe direction indices.
package vga_pkg;

   localparam int HOR_PIXELS = 1024;
   localparam int VER_PIXELS = 768;

   localparam logic [11:0] BLUE        = 12'h00f;
   localparam logic [11:0] WALL_RGB_DEF = BLUE;
   localparam logic [11:0] DOT_RGB_DEF  = 12'h0ff;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

endpackage

// File: rtl/vga_if.sv
// VGA timing/pixel bundle.
// rgb is aligned with hcount/vcount in the same cycle.
interface vga_if;

   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hblnk;
   logic        vblnk;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;

   modport in (
      input hcount, vcount, hblnk, vblnk,
      input hsync, vsync, rgb
   );

   modport out (
      output hcount, vcount, hblnk, vblnk,
      output hsync, vsync, rgb
   );

endinterface

// File: rtl/wall_probe_strip.sv
// Combinational rectangle membership test.
// Bounds are 12-bit so out-of-screen edges never alias onto pixels.
module wall_probe_strip (
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   input  logic [11:0] x0,
   input  logic [11:0] x1,
   input  logic [11:0] y0,
   input  logic [11:0] y1,
   output logic        hit
);

   logic [11:0] h;
   logic [11:0] v;

   assign h = {1'b0, hcount};
   assign v = {1'b0, vcount};

   assign hit = (h >= x0) && (h <= x1) &&
                (v >= y0) && (v <= y1);

endmodule

// File: rtl/wall_probe.sv
// Per-frame wall/dot probe around a sprite rectangle.
// Passive sink on the composed VGA stream.
module wall_probe
   import vga_pkg::*;
#(
   parameter int          SPRITE_SIZE = 16,
   parameter logic [11:0] WALL_RGB    = WALL_RGB_DEF,
   parameter logic [11:0] DOT_RGB     = DOT_RGB_DEF
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           vga_in,
   input  logic [10:0] pos_x,
   input  logic [10:0] pos_y,
   output logic [3:0]  blocked,
   output logic        dot_hit,
   output logic        frame_done,
   output logic        valid
);

   localparam logic [1:0] S_WAIT   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   localparam logic [11:0] SZ  = 12'(SPRITE_SIZE);
   localparam logic [11:0] HOR = 12'(HOR_PIXELS);
   localparam logic [11:0] VER = 12'(VER_PIXELS);

   logic [1:0]  state_q, state_d;
   logic        vblnk_q;
   logic [10:0] sx_q, sx_d;
   logic [10:0] sy_q, sy_d;
   logic [3:0]  acc_q, acc_d;
   logic        acc_dot_q, acc_dot_d;
   logic [3:0]  blocked_q, blocked_d;
   logic        dot_hit_q, dot_hit_d;
   logic        frame_done_q, frame_done_d;
   logic        valid_q, valid_d;

   logic        frame_start;
   logic        frame_end;
   logic        active;
   logic        is_wall;
   logic        is_dot;
   logic [11:0] bx, by;
   logic [11:0] bx_end, by_end;
   logic [11:0] bx_m1, by_m1;
   logic [11:0] bx_p, by_p;
   logic        hit_up, hit_down, hit_left, hit_right, hit_body;
   logic [3:0]  new_acc;
   logic        new_dot;
   logic [3:0]  edge_flags;

   assign frame_start = vblnk_q & ~vga_in.vblnk;
   assign frame_end   = ~vblnk_q & vga_in.vblnk;
   assign active      = ~vga_in.hblnk & ~vga_in.vblnk;
   assign is_wall     = vga_in.rgb == WALL_RGB;
   assign is_dot      = vga_in.rgb == DOT_RGB;

   // The first active pixel arrives with the start edge, before the
   // snapshot is registered, so probe it against the live position.
   assign bx = (state_q == S_WAIT) ? {1'b0, pos_x} : {1'b0, sx_q};
   assign by = (state_q == S_WAIT) ? {1'b0, pos_y} : {1'b0, sy_q};

   assign bx_end = bx + SZ - 12'd1;
   assign by_end = by + SZ - 12'd1;
   assign bx_m1  = bx - 12'd1;
   assign by_m1  = by - 12'd1;
   assign bx_p   = bx + SZ;
   assign by_p   = by + SZ;

   wall_probe_strip u_up (
      .hcount (vga_in.hcount), .vcount (vga_in.vcount),
      .x0 (bx), .x1 (bx_end), .y0 (by_m1), .y1 (by_m1),
      .hit (hit_up)
   );

   wall_probe_strip u_down (
      .hcount (vga_in.hcount), .vcount (vga_in.vcount),
      .x0 (bx), .x1 (bx_end), .y0 (by_p), .y1 (by_p),
      .hit (hit_down)
   );

   wall_probe_strip u_left (
      .hcount (vga_in.hcount), .vcount (vga_in.vcount),
      .x0 (bx_m1), .x1 (bx_m1), .y0 (by), .y1 (by_end),
      .hit (hit_left)
   );

   wall_probe_strip u_right (
      .hcount (vga_in.hcount), .vcount (vga_in.vcount),
      .x0 (bx_p), .x1 (bx_p), .y0 (by), .y1 (by_end),
      .hit (hit_right)
   );

   wall_probe_strip u_body (
      .hcount (vga_in.hcount), .vcount (vga_in.vcount),
      .x0 (bx), .x1 (bx_end), .y0 (by), .y1 (by_end),
      .hit (hit_body)
   );

   // Hits contributed by the current pixel and screen-edge forcing.
   always_comb begin
      new_acc            = '0;
      new_acc[DIR_UP]    = hit_up;
      new_acc[DIR_DOWN]  = hit_down;
      new_acc[DIR_LEFT]  = hit_left;
      new_acc[DIR_RIGHT] = hit_right;
      new_acc            = new_acc & {4{active & is_wall}};
      new_dot            = active & is_dot & hit_body;

      edge_flags            = '0;
      edge_flags[DIR_UP]    = sy_q == 11'd0;
      edge_flags[DIR_LEFT]  = sx_q == 11'd0;
      edge_flags[DIR_DOWN]  = ({1'b0, sy_q} + SZ) >= VER;
      edge_flags[DIR_RIGHT] = ({1'b0, sx_q} + SZ) >= HOR;
   end

   // Frame FSM: snapshot, sticky accumulate, one-cycle commit.
   always_comb begin
      state_d      = state_q;
      sx_d         = sx_q;
      sy_d         = sy_q;
      acc_d        = acc_q;
      acc_dot_d    = acc_dot_q;
      blocked_d    = blocked_q;
      dot_hit_d    = dot_hit_q;
      frame_done_d = 1'b0;
      valid_d      = valid_q;
      unique case (state_q)
         S_WAIT: begin
            if (frame_start) begin
               state_d   = S_SCAN;
               sx_d      = pos_x;
               sy_d      = pos_y;
               acc_d     = new_acc;
               acc_dot_d = new_dot;
            end
         end
         S_SCAN: begin
            acc_d     = acc_q | new_acc;
            acc_dot_d = acc_dot_q | new_dot;
            if (frame_end) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            blocked_d    = acc_q | edge_flags;
            dot_hit_d    = acc_dot_q;
            frame_done_d = 1'b1;
            valid_d      = 1'b1;
            acc_d        = '0;
            acc_dot_d    = 1'b0;
            state_d      = S_WAIT;
         end
         default: begin
            state_d   = S_WAIT;
            acc_d     = '0;
            acc_dot_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_WAIT;
         vblnk_q      <= 1'b0;
         sx_q         <= '0;
         sy_q         <= '0;
         acc_q        <= '0;
         acc_dot_q    <= 1'b0;
         blocked_q    <= '0;
         dot_hit_q    <= 1'b0;
         frame_done_q <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         vblnk_q      <= vga_in.vblnk;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         acc_q        <= acc_d;
         acc_dot_q    <= acc_dot_d;
         blocked_q    <= blocked_d;
         dot_hit_q    <= dot_hit_d;
         frame_done_q <= frame_done_d;
         valid_q      <= valid_d;
      end
   end

   assign blocked    = blocked_q;
   assign dot_hit    = dot_hit_q;
   assign frame_done = frame_done_q;
   assign valid      = valid_q;

endmodule
